// File: rtl/hazard_pkg.sv
`default_nettype none
// ==========================================================================
// hazard_pkg : shared select encodings and pipeline stage-tag type
// Rev 1.0
// ==========================================================================
package hazard_pkg;

    // Stage tags carry rd at a fixed maximum width; narrower register
    // addresses are zero-extended on entry.
    localparam int TAG_RD_W = 8;

    localparam logic [1:0] SEL_RF    = 2'b00;
    localparam logic [1:0] SEL_ALT   = 2'b01;
    localparam logic [1:0] SEL_EXMEM = 2'b10;
    localparam logic [1:0] SEL_MEMWB = 2'b11;

    typedef logic [TAG_RD_W-1:0] tag_rd_t;

    typedef struct packed {
        logic    valid;
        tag_rd_t rd;
        logic    wr;
        logic    load;
    } stage_tag_t;

    localparam stage_tag_t c_tag_bubble = '0;

endpackage
`default_nettype wire

// File: rtl/fwd_src_sel.sv
`default_nettype none
// ==========================================================================
// fwd_src_sel : operand-source select and load-use detect for one source
// Rev 1.0
// ==========================================================================
module fwd_src_sel
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 2,
    parameter bit ZERO_REG   = 1'b1
) (
    input  logic [REG_ADDR_W-1:0] src,
    input  logic                  used,
    input  logic                  override,
    input  stage_tag_t            ex_tag,
    input  stage_tag_t            mem_tag,
    output logic [1:0]            sel,
    output logic                  load_use
);

    logic    w_live;
    logic    w_ex_hit;
    logic    w_mem_hit;
    logic    w_unused_mem_load;
    tag_rd_t w_src_ext;

    assign w_src_ext = tag_rd_t'(src);
    assign w_live    = used & ~(ZERO_REG & (src == '0));
    assign w_ex_hit  = w_live & ex_tag.valid  & ex_tag.wr  & (ex_tag.rd  == w_src_ext);
    assign w_mem_hit = w_live & mem_tag.valid & mem_tag.wr & (mem_tag.rd == w_src_ext);
    assign load_use  = w_ex_hit & ex_tag.load;

    // A load already past EX has its data on MEM/WB, so its load flag is moot.
    assign w_unused_mem_load = mem_tag.load;

    always_comb begin
        sel = SEL_RF;
        if (override) begin
            sel = SEL_ALT;
        end else if (w_ex_hit) begin
            sel = ex_tag.load ? SEL_RF : SEL_EXMEM;
        end else if (w_mem_hit) begin
            sel = SEL_MEMWB;
        end
    end

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ==========================================================================
// hazard_scoreboard : RAW forwarding, load-use and multi-cycle stall control
// Rev 1.0
// ==========================================================================
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 2,
    parameter int MUL_LAT    = 3,
    parameter bit ZERO_REG   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic                  id_in1_alt,
    input  logic                  id_in2_imm,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_rd_wr,
    input  logic                  id_is_load,
    input  logic                  id_is_multi,
    input  logic                  flush,
    input  logic                  mem_stall,
    output logic                  stall_id,
    output logic                  ex_busy,
    output logic [1:0]            ex_in1_sel,
    output logic [1:0]            ex_in2_sel
);

    localparam int             CNT_W        = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [CNT_W-1:0] c_mul_reload = CNT_W'((MUL_LAT > 1) ? (MUL_LAT - 1) : 0);

    stage_tag_t       r_ex;
    stage_tag_t       r_mem;
    stage_tag_t       r_wb;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_in1_sel;
    logic [1:0]       r_in2_sel;

    stage_tag_t w_id_tag;
    logic [1:0] w_sel1;
    logic [1:0] w_sel2;
    logic       w_lu1;
    logic       w_lu2;
    logic       w_load_use;
    logic       w_busy;
    logic       w_enter;
    logic       w_unused_wb;

    fwd_src_sel #(
        .REG_ADDR_W (REG_ADDR_W),
        .ZERO_REG   (ZERO_REG)
    ) u_src1 (
        .src      (id_rs1),
        .used     (id_rs1_used),
        .override (id_in1_alt),
        .ex_tag   (r_ex),
        .mem_tag  (r_mem),
        .sel      (w_sel1),
        .load_use (w_lu1)
    );

    fwd_src_sel #(
        .REG_ADDR_W (REG_ADDR_W),
        .ZERO_REG   (ZERO_REG)
    ) u_src2 (
        .src      (id_rs2),
        .used     (id_rs2_used),
        .override (id_in2_imm),
        .ex_tag   (r_ex),
        .mem_tag  (r_mem),
        .sel      (w_sel2),
        .load_use (w_lu2)
    );

    assign w_id_tag   = '{valid: 1'b1, rd: tag_rd_t'(id_rd), wr: id_rd_wr, load: id_is_load};
    assign w_load_use = w_lu1 | w_lu2;
    assign w_busy     = (r_cnt != '0);
    assign w_enter    = id_valid & ~w_load_use & ~flush;

    assign stall_id   = mem_stall | w_busy | (id_valid & w_load_use & ~flush);
    assign ex_busy    = w_busy;
    assign ex_in1_sel = r_in1_sel;
    assign ex_in2_sel = r_in2_sel;

    // WB is tracked for completeness only: the register file is write-first.
    assign w_unused_wb = ^r_wb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex      <= c_tag_bubble;
            r_mem     <= c_tag_bubble;
            r_wb      <= c_tag_bubble;
            r_cnt     <= '0;
            r_in1_sel <= SEL_RF;
            r_in2_sel <= SEL_RF;
        end else if (!mem_stall) begin
            r_wb <= r_mem;
            if (w_busy) begin
                // EX and its selects hold; the multi-cycle unit already latched operands.
                r_mem <= c_tag_bubble;
                r_cnt <= r_cnt - CNT_W'(1);
            end else begin
                r_mem <= r_ex;
                if (w_enter) begin
                    r_ex      <= w_id_tag;
                    r_in1_sel <= w_sel1;
                    r_in2_sel <= w_sel2;
                    r_cnt     <= id_is_multi ? c_mul_reload : '0;
                end else begin
                    r_ex      <= c_tag_bubble;
                    r_in1_sel <= SEL_RF;
                    r_in2_sel <= SEL_RF;
                end
            end
        end
    end

endmodule
`default_nettype wire
